// File: rtl/nco_pkg.sv
// nco_pkg -- shared constants and helpers for the axis_nco_bank NCO bank.
//
// Contents:
//   LANE_W / HALF_W / SIN_LSB / COS_LSB : output lane packing offsets
//   LFSR_W / LFSR_TAP_A / LFSR_TAP_B    : dither LFSR geometry and taps
//   quadrant_t                          : quadrant decode of the phase MSBs
//   lut_entry()                         : quarter-wave sine table contents
//   sext_dither()                       : signed dither slice of an LFSR state
package nco_pkg;

  localparam int LANE_W  = 32;
  localparam int HALF_W  = 16;
  localparam int SIN_LSB = 16;
  localparam int COS_LSB = 0;

  localparam int LFSR_W     = 32;
  localparam int LFSR_TAP_A = 31;
  localparam int LFSR_TAP_B = 28;

  localparam real PI = 3.14159265358979323846;

  // Top two phase bits select where in the full cycle we are.
  typedef enum logic [1:0] {
    Q_RISE     = 2'b00,
    Q_FALL     = 2'b01,
    Q_NEG_RISE = 2'b10,
    Q_NEG_FALL = 2'b11
  } quadrant_t;

  // Quarter-wave table entry k for a full cycle of 2^phase_bits samples,
  // rounded to nearest at full-scale amplitude 2^(amp_bits-1)-1.
  function automatic int lut_entry(int k, int phase_bits, int amp_bits);
    real amp;
    real x;
    amp = real'((1 << (amp_bits - 1)) - 1);
    x   = amp * $sin(2.0 * PI * real'(k) / real'(1 << phase_bits));
    return int'($floor(x + 0.5));
  endfunction

  // Low 'bits' bits of the LFSR state, sign-extended; zero when bits is 0.
  function automatic logic [63:0] sext_dither(logic [LFSR_W-1:0] state, int bits);
    logic [63:0] r;
    r = '0;
    if (bits > 0) begin
      for (int i = 0; i < 64; i++) begin
        r[i] = (i < bits) ? state[i] : state[bits-1];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_nco_bank_if.sv
// axis_nco_bank_if -- AXI-Stream style output bus of the NCO bank.
//
// Signals:
//   tdata  : NUM_CH lanes of 32 bits, {sine[31:16], cosine[15:0]} per lane
//   tvalid : beat valid (driven by master)
//   tready : beat accepted (driven by slave)
interface axis_nco_bank_if #(
  parameter int NUM_CH = 2
);
  logic [NUM_CH*32-1:0] tdata;
  logic                 tvalid;
  logic                 tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/nco_qlut.sv
// nco_qlut -- quarter-wave sine ROM with quadrant mapping and a registered
// output. No reset: the output register is qualified by the parent's
// valid pipeline instead.
//
// Ports:
//   clk   : clock
//   en    : pipeline enable, output register loads only when high
//   phase : PHASE_BITS full-cycle phase
//   amp   : signed AMP_BITS sine of phase, one cycle after en
module nco_qlut
  import nco_pkg::*;
#(
  parameter int PHASE_BITS = 12,
  parameter int AMP_BITS   = 14
) (
  input  logic                       clk,
  input  logic                       en,
  input  logic [PHASE_BITS-1:0]      phase,
  output logic signed [AMP_BITS-1:0] amp
);

  localparam int QN = 1 << (PHASE_BITS - 2);

  logic signed [AMP_BITS-1:0] lut [0:QN];
  quadrant_t                  q;
  logic [PHASE_BITS-3:0]      low;
  logic [PHASE_BITS-2:0]      idx;
  logic                       neg;

  // Table contents are constant; this evaluates once and folds to a ROM.
  always_comb begin
    for (int k = 0; k <= QN; k++) begin
      lut[k] = AMP_BITS'(lut_entry(k, PHASE_BITS, AMP_BITS));
    end
  end

  // Falling quadrants walk the table backwards from N/4, so the index
  // needs one more bit than 'low' to reach entry N/4 itself.
  always_comb begin
    q   = quadrant_t'(phase[PHASE_BITS-1 -: 2]);
    low = phase[PHASE_BITS-3:0];
    idx = {1'b0, low};
    neg = 1'b0;
    case (q)
      Q_RISE:     idx = {1'b0, low};
      Q_FALL:     idx = (PHASE_BITS-1)'(QN) - {1'b0, low};
      Q_NEG_RISE: begin
        idx = {1'b0, low};
        neg = 1'b1;
      end
      Q_NEG_FALL: begin
        idx = (PHASE_BITS-1)'(QN) - {1'b0, low};
        neg = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (en) amp <= neg ? -lut[idx] : lut[idx];
  end

endmodule

// File: rtl/axis_nco_bank.sv
// axis_nco_bank -- bank of NUM_CH numerically controlled oscillators with
// double-buffered frequency/phase-offset registers and an AXI-Stream output.
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   cfg_we, cfg_ch      : write cfg_freq/cfg_poff into shadow[cfg_ch]
//   cfg_freq, cfg_poff  : shadow frequency word and phase offset
//   cfg_commit          : copy all shadows into the active registers
//   sync                : clear all phase accumulators
//   m_axis              : output stream, one {sin,cos} lane per channel
module axis_nco_bank
  import nco_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int ACCUM_WIDTH = 32,
  parameter int PHASE_BITS  = 12,
  parameter int AMP_BITS    = 14,
  parameter int DITHER_BITS = 0,
  parameter int SEED        = 36421
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           cfg_we,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [ACCUM_WIDTH-1:0]                         cfg_freq,
  input  logic [ACCUM_WIDTH-1:0]                         cfg_poff,
  input  logic                                           cfg_commit,
  input  logic                                           sync,
  axis_nco_bank_if.master                                m_axis
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int QN   = 1 << (PHASE_BITS - 2);

  logic [2:0]               valid_pipe;
  logic                     en;
  logic [NUM_CH*LANE_W-1:0] tdata;

  assign en            = !valid_pipe[2] || m_axis.tready;
  assign m_axis.tvalid = valid_pipe[2];
  assign m_axis.tdata  = tdata;

  // One marker per pipeline stage; tvalid is the marker leaving stage 3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     valid_pipe <= '0;
    else if (en) valid_pipe <= {valid_pipe[1:0], 1'b1};
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic                       wr;
    logic [ACCUM_WIDTH-1:0]     shadow_freq;
    logic [ACCUM_WIDTH-1:0]     shadow_poff;
    logic [ACCUM_WIDTH-1:0]     active_freq;
    logic [ACCUM_WIDTH-1:0]     active_poff;
    logic [ACCUM_WIDTH-1:0]     acc;
    logic [ACCUM_WIDTH-1:0]     dither;
    logic [LFSR_W-1:0]          lfsr;
    logic [PHASE_BITS-1:0]      phase_next;
    logic [PHASE_BITS-1:0]      phase_sin;
    logic [PHASE_BITS-1:0]      phase_cos;
    logic signed [AMP_BITS-1:0] sin_amp;
    logic signed [AMP_BITS-1:0] cos_amp;

    // Out-of-range channel numbers simply match no lane.
    assign wr = cfg_we && (cfg_ch == CH_W'(c));

    // Config registers run regardless of stalls. A write landing in the
    // commit cycle is forwarded straight into the active copy.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        shadow_freq <= '0;
        shadow_poff <= '0;
        active_freq <= '0;
        active_poff <= '0;
      end else begin
        if (wr) begin
          shadow_freq <= cfg_freq;
          shadow_poff <= cfg_poff;
        end
        if (cfg_commit) begin
          active_freq <= wr ? cfg_freq : shadow_freq;
          active_poff <= wr ? cfg_poff : shadow_poff;
        end
      end
    end

    // Stage 1: sync overrides both the stall hold and the add.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)       acc <= '0;
      else if (sync) acc <= '0;
      else if (en)   acc <= acc + active_freq;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst)     lfsr <= LFSR_W'(SEED + c);
      else if (en) lfsr <= {lfsr[LFSR_W-2:0], lfsr[LFSR_TAP_A] ^ lfsr[LFSR_TAP_B]};
    end

    assign dither = ACCUM_WIDTH'(sext_dither(lfsr, DITHER_BITS));

    // Stage 2: keep only the top PHASE_BITS of the wrapped phase sum.
    assign phase_next = PHASE_BITS'((acc + active_poff + dither) >> (ACCUM_WIDTH - PHASE_BITS));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        phase_sin <= '0;
        phase_cos <= '0;
      end else if (en) begin
        phase_sin <= phase_next;
        phase_cos <= phase_next + PHASE_BITS'(QN);
      end
    end

    // Stage 3: registered table lookups.
    nco_qlut #(.PHASE_BITS(PHASE_BITS), .AMP_BITS(AMP_BITS)) u_sin (
      .clk   (clk),
      .en    (en),
      .phase (phase_sin),
      .amp   (sin_amp)
    );

    nco_qlut #(.PHASE_BITS(PHASE_BITS), .AMP_BITS(AMP_BITS)) u_cos (
      .clk   (clk),
      .en    (en),
      .phase (phase_cos),
      .amp   (cos_amp)
    );

    // The lookup registers have no reset, so gating with tvalid gives a
    // clean zero bus during and right after reset.
    assign tdata[LANE_W*c + SIN_LSB +: HALF_W] = valid_pipe[2] ? HALF_W'(sin_amp) : '0;
    assign tdata[LANE_W*c + COS_LSB +: HALF_W] = valid_pipe[2] ? HALF_W'(cos_amp) : '0;
  end

endmodule
